// File: rtl/cpu_io_port_pkg.sv
// cpu_io_port_pkg: register offsets and sizing helpers shared by the I/O port.
package cpu_io_port_pkg;
  localparam logic [1:0] REG_DATA  = 2'd0;
  localparam logic [1:0] REG_DDR   = 2'd1;
  localparam logic [1:0] REG_IFLAG = 2'd2;
  localparam logic [1:0] REG_IMASK = 2'd3;
  // At least one bit wide so a never-fading configuration still elaborates.
  function automatic int fade_cnt_w(input int fade_cycles);
    return (fade_cycles < 1) ? 1 : $clog2(fade_cycles + 1);
  endfunction
endpackage

// File: rtl/io_port_fade_cell.sv
// io_port_fade_cell: retained value and decay counter of one unbonded port bit.
module io_port_fade_cell
  import cpu_io_port_pkg::*;
#(
  parameter int   FADE_CYCLES = 1000,
  parameter logic FADE_VALUE  = 1'b0
) (
  input  logic clock,
  input  logic reset,
  input  logic load,
  input  logic load_val,
  input  logic ddr,
  output logic retained
);
  localparam int CW = fade_cnt_w(FADE_CYCLES);
  localparam logic [CW-1:0] RELOAD = CW'(FADE_CYCLES);
  logic [CW-1:0] cnt_q, cnt_d;
  logic ret_q, ret_d;
  always_comb begin
    cnt_d = load ? RELOAD : ddr ? '0 : (cnt_q != '0) ? cnt_q - CW'(1) : cnt_q;
    ret_d = load ? load_val : (!ddr && cnt_q == CW'(1)) ? FADE_VALUE : ret_q;
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
      ret_q <= FADE_VALUE;
    end else begin
      cnt_q <= cnt_d;
      ret_q <= ret_d;
    end
  end
  assign retained = ret_q;
endmodule

// File: rtl/cpu_io_port.sv
// cpu_io_port: parametrised processor I/O port with synchronised inputs,
// unbonded-bit retention and edge-detect interrupt flags.
module cpu_io_port
  import cpu_io_port_pkg::*;
#(
  parameter int               ADDR_W      = 16,
  parameter logic [ADDR_W-1:0] BASE       = '0,
  parameter logic [7:0]       IMPL_MASK   = 8'hDF,
  parameter logic [7:0]       FLOAT_MASK  = 8'hC0,
  parameter int               FADE_CYCLES = 1000,
  parameter logic [7:0]       FADE_VALUE  = 8'h00,
  parameter int               SYNC_STAGES = 2,
  parameter logic [7:0]       EDGE_RISE   = 8'h00
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cs,
  input  logic              r_w,
  input  logic [ADDR_W-1:0] addr,
  input  logic [7:0]        wdata,
  output logic [7:0]        rdata,
  output logic              rdata_oe,
  input  logic [7:0]        pio_in,
  output logic [7:0]        pio_out,
  output logic [7:0]        pio_oe,
  output logic              irq
);
  localparam int AW = $clog2(SYNC_STAGES + 2);
  localparam logic [AW-1:0] ARM_N = AW'(SYNC_STAGES + 1);
  logic sel, rd, wr, data_wr, armed;
  logic [1:0] off;
  logic [7:0] data_q, data_d, ddr_q, ddr_d, iflag_q, iflag_d, imask_q, imask_d;
  logic [7:0] prev_q, sync, retained, edges, qual, data_rd;
  logic [SYNC_STAGES-1:0][7:0] sync_q, sync_d;
  logic [AW-1:0] arm_q, arm_d;
  always_comb begin
    off      = addr[1:0];
    sel      = cs && (addr[ADDR_W-1:2] == BASE[ADDR_W-1:2]);
    rd       = sel && r_w;
    wr       = sel && !r_w;
    data_wr  = wr && off == REG_DATA;
    sync     = sync_q[SYNC_STAGES-1];
    sync_d   = {sync_q[SYNC_STAGES-2:0], pio_in};
    armed    = arm_q == ARM_N;
    arm_d    = armed ? arm_q : arm_q + AW'(1);
    data_d   = data_wr ? wdata & IMPL_MASK : data_q;
    ddr_d    = (wr && off == REG_DDR) ? wdata & IMPL_MASK : ddr_q;
    imask_d  = (wr && off == REG_IMASK) ? wdata & IMPL_MASK : imask_q;
    edges    = (EDGE_RISE & sync & ~prev_q) | (~EDGE_RISE & ~sync & prev_q);
    qual     = edges & IMPL_MASK & ~FLOAT_MASK & ~ddr_q & {8{armed}};
    // A new edge wins over a simultaneous write-1-to-clear.
    iflag_d  = (iflag_q & ~((wr && off == REG_IFLAG) ? wdata & IMPL_MASK : 8'h00)) | qual;
    data_rd  = IMPL_MASK & ((ddr_q & data_q) | (~ddr_q & FLOAT_MASK & retained) |
                            (~ddr_q & ~FLOAT_MASK & sync));
    rdata    = !rd ? 8'h00 : off == REG_DATA ? data_rd : off == REG_DDR ? ddr_q :
               off == REG_IFLAG ? iflag_q : imask_q;
    rdata_oe = rd;
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      data_q  <= '0;
      ddr_q   <= '0;
      iflag_q <= '0;
      imask_q <= '0;
      prev_q  <= '0;
      sync_q  <= '0;
      arm_q   <= '0;
    end else begin
      data_q  <= data_d;
      ddr_q   <= ddr_d;
      iflag_q <= iflag_d;
      imask_q <= imask_d;
      prev_q  <= sync;
      sync_q  <= sync_d;
      arm_q   <= arm_d;
    end
  end
  for (genvar i = 0; i < 8; i++) begin : g_bit
    if (FLOAT_MASK[i]) begin : g_fade
      io_port_fade_cell #(
        .FADE_CYCLES(FADE_CYCLES),
        .FADE_VALUE (FADE_VALUE[i])
      ) u_cell (
        .clock   (clock),
        .reset   (reset),
        .load    (data_wr | (ddr_q[i] & ~ddr_d[i])),
        .load_val(data_wr ? wdata[i] : data_q[i]),
        .ddr     (ddr_q[i]),
        .retained(retained[i])
      );
    end else begin : g_none
      assign retained[i] = 1'b0;
    end
  end
  assign pio_out = data_q;
  assign pio_oe  = ddr_q;
  assign irq     = |(iflag_q & imask_q);
endmodule

// File: tb/tb_cpu_io_port.sv
// tb_cpu_io_port: directed and random bus/pin stimulus on two port configurations
// (fading/falling-edge and non-fading/rising-edge) checked against a cycle model.
module tb_cpu_io_port;
  localparam logic [15:0] BASE = 16'hD000;
  localparam int S = 2;
  localparam logic [7:0] IMPL = 8'hDF;
  localparam logic [7:0] FLOAT = 8'hC0;
  localparam logic [7:0] FV = 8'h00;
  logic clock = 1'b0, reset = 1'b1, cs = 1'b0, r_w = 1'b1;
  logic [15:0] addr = BASE;
  logic [7:0] wdata = 8'h00, pio_in = 8'h00;
  logic [7:0] rdata_a, pio_out_a, pio_oe_a, rdata_b, pio_out_b, pio_oe_b;
  logic rdata_oe_a, irq_a, rdata_oe_b, irq_b;
  int total = 0, bad = 0;
  cpu_io_port #(.BASE(BASE), .FADE_CYCLES(16), .EDGE_RISE(8'h00)) dut_a (
    .clock(clock), .reset(reset), .cs(cs), .r_w(r_w), .addr(addr), .wdata(wdata),
    .rdata(rdata_a), .rdata_oe(rdata_oe_a), .pio_in(pio_in), .pio_out(pio_out_a),
    .pio_oe(pio_oe_a), .irq(irq_a));
  cpu_io_port #(.BASE(BASE), .FADE_CYCLES(0), .EDGE_RISE(8'hFF)) dut_b (
    .clock(clock), .reset(reset), .cs(cs), .r_w(r_w), .addr(addr), .wdata(wdata),
    .rdata(rdata_b), .rdata_oe(rdata_oe_b), .pio_in(pio_in), .pio_out(pio_out_b),
    .pio_oe(pio_oe_b), .irq(irq_b));
  always #5 clock = ~clock;
  int cyc;
  logic [7:0] hist[$];
  logic [7:0] m_data, m_ddr, m_imask;
  logic [7:0] m_iflag[2];
  logic [7:0] ret_val[2];
  int load_cyc[2][8];
  function automatic int fade_of(input int k);
    return (k == 0) ? 16 : 0;
  endfunction
  function automatic logic [7:0] er_of(input int k);
    return (k == 0) ? 8'h00 : 8'hFF;
  endfunction
  function automatic logic [7:0] m_sync(input int c);
    if (c < S) return 8'h00;
    return hist[c-S];
  endfunction
  function automatic logic [7:0] m_ret(input int k);
    logic [7:0] r;
    for (int i = 0; i < 8; i++)
      r[i] = (fade_of(k) != 0 && cyc - load_cyc[k][i] >= fade_of(k)) ? FV[i] : ret_val[k][i];
    return r;
  endfunction
  function automatic logic [7:0] m_read(input int k, input logic [1:0] off);
    case (off)
      2'd0: return IMPL & ((m_ddr & m_data) | (~m_ddr & FLOAT & m_ret(k)) |
                           (~m_ddr & ~FLOAT & m_sync(cyc)));
      2'd1: return m_ddr;
      2'd2: return m_iflag[k];
      default: return m_imask;
    endcase
  endfunction
  function automatic logic [7:0] m_edge(input int k);
    logic [7:0] s, p, e;
    s = m_sync(cyc);
    p = m_sync(cyc - 1);
    e = (er_of(k) & s & ~p) | (~er_of(k) & ~s & p);
    return (cyc >= S + 1) ? e & IMPL & ~FLOAT & ~m_ddr : 8'h00;
  endfunction
  task automatic check(input string tag, input int k, input logic [7:0] got, input logic [7:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s[%0d] got=%h exp=%h", tag, k, got, exp);
    end
  endtask
  task automatic model_reset();
    cyc = 0;
    hist.delete();
    m_data = 8'h00;
    m_ddr = 8'h00;
    m_imask = 8'h00;
    for (int k = 0; k < 2; k++) begin
      m_iflag[k] = 8'h00;
      ret_val[k] = FV;
      for (int i = 0; i < 8; i++) load_cyc[k][i] = 0;
    end
  endtask
  task automatic op(input logic c, input logic rw, input logic [1:0] off, input logic [7:0] wd,
                    input logic hit, output logic [7:0] ra, output logic [7:0] rb);
    logic sel, rd, wr;
    logic [7:0] nd;
    cs = c;
    r_w = rw;
    addr = hit ? {BASE[15:2], off} : {BASE[15:2] ^ 14'h0001, off};
    wdata = wd;
    @(negedge clock);
    sel = c && hit;
    rd = sel && rw;
    wr = sel && !rw;
    check("rdata", 0, rdata_a, rd ? m_read(0, off) : 8'h00);
    check("rdata", 1, rdata_b, rd ? m_read(1, off) : 8'h00);
    check("rdata_oe", 0, {7'd0, rdata_oe_a}, {7'd0, rd});
    check("rdata_oe", 1, {7'd0, rdata_oe_b}, {7'd0, rd});
    check("pio_out", 0, pio_out_a, m_data);
    check("pio_out", 1, pio_out_b, m_data);
    check("pio_oe", 0, pio_oe_a, m_ddr);
    check("pio_oe", 1, pio_oe_b, m_ddr);
    check("irq", 0, {7'd0, irq_a}, {7'd0, |(m_iflag[0] & m_imask)});
    check("irq", 1, {7'd0, irq_b}, {7'd0, |(m_iflag[1] & m_imask)});
    ra = rdata_a;
    rb = rdata_b;
    for (int k = 0; k < 2; k++)
      m_iflag[k] = (m_iflag[k] & ~((wr && off == 2'd2) ? wd & IMPL : 8'h00)) | m_edge(k);
    if (wr && off == 2'd0) begin
      m_data = wd & IMPL;
      for (int k = 0; k < 2; k++)
        for (int i = 0; i < 8; i++)
          if (FLOAT[i]) begin
            ret_val[k][i] = wd[i];
            load_cyc[k][i] = cyc + 1;
          end
    end
    if (wr && off == 2'd1) begin
      nd = wd & IMPL;
      for (int k = 0; k < 2; k++)
        for (int i = 0; i < 8; i++)
          if (FLOAT[i] && m_ddr[i] && !nd[i]) begin
            ret_val[k][i] = m_data[i];
            load_cyc[k][i] = cyc + 1;
          end
      m_ddr = nd;
    end
    if (wr && off == 2'd3) m_imask = wd & IMPL;
    hist.push_back(pio_in);
    cyc++;
    @(posedge clock);
    #1;
  endtask
  task automatic wr_reg(input logic [1:0] off, input logic [7:0] wd);
    logic [7:0] ra, rb;
    op(1'b1, 1'b0, off, wd, 1'b1, ra, rb);
  endtask
  task automatic idle(input int n);
    logic [7:0] ra, rb;
    for (int j = 0; j < n; j++) op(1'b0, 1'b1, 2'd0, 8'h00, 1'b1, ra, rb);
  endtask
  initial begin
    logic [7:0] ra, rb;
    model_reset();
    #2;
    check("rst_pio_out", 0, pio_out_a, 8'h00);
    check("rst_pio_oe", 0, pio_oe_a, 8'h00);
    check("rst_irq", 0, {7'd0, irq_a}, 8'h00);
    @(posedge clock);
    @(posedge clock);
    #1 reset = 1'b0;
    // Register write and implemented-bit mask
    wr_reg(2'd1, 8'hFF);
    wr_reg(2'd0, 8'hA5);
    op(1'b1, 1'b1, 2'd0, 8'h00, 1'b1, ra, rb);
    check("t1_data", 0, ra, 8'h85);
    check("t1_pio_oe", 0, pio_oe_a, 8'hDF);
    check("t1_pio_out", 0, pio_out_a, 8'h85);
    // Synchroniser latency with bits 7:6 retained
    wr_reg(2'd1, 8'h00);
    pio_in = 8'h1F;
    for (int j = 1; j <= 4; j++) begin
      op(1'b1, 1'b1, 2'd0, 8'h00, 1'b1, ra, rb);
      check("t2_sync", j, ra, 8'h80 | ((j >= 3) ? 8'h1F : 8'h00));
    end
    // Fade timing versus a never-fading instance
    wr_reg(2'd1, 8'hC0);
    wr_reg(2'd0, 8'hC0);
    wr_reg(2'd1, 8'h00);
    for (int j = 1; j <= 20; j++) begin
      op(1'b1, 1'b1, 2'd0, 8'h00, 1'b1, ra, rb);
      check("t3_fade", j, {6'd0, ra[7:6]}, (j <= 16) ? 8'h03 : 8'h00);
      check("t3_hold", j, {6'd0, rb[7:6]}, 8'h03);
    end
    // Edge flag, irq and write-1-to-clear
    pio_in = 8'h01;
    idle(4);
    wr_reg(2'd2, 8'hFF);
    wr_reg(2'd3, 8'h01);
    pio_in = 8'h00;
    for (int j = 1; j <= 5; j++) begin
      idle(1);
      check("t4_irq", j, {7'd0, irq_a}, (j >= 3) ? 8'h01 : 8'h00);
    end
    op(1'b1, 1'b1, 2'd2, 8'h00, 1'b1, ra, rb);
    check("t4_iflag", 0, ra, 8'h01);
    wr_reg(2'd2, 8'h01);
    check("t4_clr", 0, {7'd0, irq_a}, 8'h00);
    // Set beats simultaneous clear; ddr=1 blocks flagging
    pio_in = 8'h01;
    idle(3);
    wr_reg(2'd2, 8'hFF);
    pio_in = 8'h00;
    idle(2);
    wr_reg(2'd2, 8'h01);
    op(1'b1, 1'b1, 2'd2, 8'h00, 1'b1, ra, rb);
    check("t5_setwins", 0, ra & 8'h01, 8'h01);
    wr_reg(2'd2, 8'hFF);
    wr_reg(2'd1, 8'h01);
    pio_in = 8'h01;
    idle(3);
    pio_in = 8'h00;
    idle(4);
    op(1'b1, 1'b1, 2'd2, 8'h00, 1'b1, ra, rb);
    check("t5_ddr_block", 0, ra, 8'h00);
    // Reset mid-fade with a pending flag
    wr_reg(2'd1, 8'hC0);
    wr_reg(2'd0, 8'hC0);
    wr_reg(2'd1, 8'h00);
    wr_reg(2'd3, 8'hFF);
    pio_in = 8'h01;
    idle(3);
    pio_in = 8'h00;
    idle(3);
    check("t6_pre_irq", 0, {7'd0, irq_a}, 8'h01);
    pio_in = 8'hFF;
    cs = 1'b1;
    r_w = 1'b1;
    addr = BASE;
    #2 reset = 1'b1;
    #1;
    check("t6_pio_out", 0, pio_out_a, 8'h00);
    check("t6_pio_oe", 0, pio_oe_a, 8'h00);
    check("t6_irq", 0, {7'd0, irq_a}, 8'h00);
    check("t6_data", 0, rdata_a, 8'h00);
    check("t6_data", 1, rdata_b, 8'h00);
    @(posedge clock);
    #1 reset = 1'b0;
    model_reset();
    op(1'b1, 1'b1, 2'd0, 8'h00, 1'b1, ra, rb);
    check("t6_retained", 0, ra & 8'hC0, FV & 8'hC0);
    idle(S + 3);
    op(1'b1, 1'b1, 2'd2, 8'h00, 1'b1, ra, rb);
    check("t6_no_flag", 1, rb, 8'h00);
    // Random bus traffic and pin activity
    for (int j = 0; j < 400; j++) begin
      if ($urandom_range(3) == 0) pio_in = 8'($urandom);
      op(1'($urandom), 1'($urandom), 2'($urandom), 8'($urandom),
         $urandom_range(3) != 0, ra, rb);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
